// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle controller, ALU and datapath:
// FSM state codes, instruction opcodes/functs, ALU operation codes and
// datapath mux selects.
package mc_defs;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operation codes, shared with the ALU
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b100;

  // Datapath mux selects
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REGA   = 1'b1;
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;
  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_OUT   = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle controller and its datapath.
// master: controller side (consumes IR fields, Zero, mem_ready; drives
//         ALU op, mux selects and enables).
// slave : datapath side (the reverse directions).
interface mc_controller_if;
  import mc_defs::*;

  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                Zero;
  logic                mem_ready;

  logic [ALU_OP_W-1:0] ALU_opc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSrc;
  logic                pc_write;
  logic                IorD;
  logic                mem_read;
  logic                mem_write;
  logic                IRWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                RegWrite;
  logic                illegal;

  modport master (
    input  opcode, funct, Zero, mem_ready,
    output ALU_opc, ALUSrcA, ALUSrcB, PCSrc, pc_write, IorD,
           mem_read, mem_write, IRWrite, RegDst, MemtoReg, RegWrite, illegal
  );

  modport slave (
    output opcode, funct, Zero, mem_ready,
    input  ALU_opc, ALUSrcA, ALUSrcB, PCSrc, pc_write, IorD,
           mem_read, mem_write, IRWrite, RegDst, MemtoReg, RegWrite, illegal
  );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation code and flags
// whether the funct is supported.
//   funct_i   : IR[5:0]
//   alu_opc_o : ALU operation (ADD when unsupported)
//   valid_o   : 1 when funct is a supported R-type operation
module alu_decoder
  import mc_defs::*;
(
  input  logic [FUNCT_W-1:0]  funct_i,
  output logic [ALU_OP_W-1:0] alu_opc_o,
  output logic                valid_o
);

  always_comb begin
    alu_opc_o = ALU_ADD;
    valid_o   = 1'b1;
    case (funct_i)
      FN_ADD:  alu_opc_o = ALU_ADD;
      FN_SUB:  alu_opc_o = ALU_SUB;
      FN_AND:  alu_opc_o = ALU_AND;
      FN_OR:   alu_opc_o = ALU_OR;
      FN_SLT:  alu_opc_o = ALU_SLT;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM. Sequences fetch/decode and the execute,
// memory and write-back steps of lw, sw, R-type, beq, bne, addi, slti,
// andi and j. Outputs decode combinationally from state (plus
// mem_ready, Zero, opcode/funct where the instruction needs them).
//   clk : clock, all state changes on posedge
//   rst : synchronous active-high reset; outputs held at defaults
//   bus : control bus (master side), see mc_controller_if
module mc_controller
  import mc_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  mc_controller_if.master bus
);

  state_t              state_q, state_d;
  // lw/sw choice is captured in decode so MEMADR does not depend on IR.
  logic                is_store_q, is_store_d;
  logic [ALU_OP_W-1:0] rt_opc;
  logic                rt_valid;

  alu_decoder u_alu_decoder (
    .funct_i   (bus.funct),
    .alu_opc_o (rt_opc),
    .valid_o   (rt_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    bus.ALU_opc  = ALU_ADD;
    bus.ALUSrcA  = SRCA_PC;
    bus.ALUSrcB  = SRCB_REGB;
    bus.PCSrc    = PCSRC_ALU;
    bus.pc_write = 1'b0;
    bus.IorD     = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write= 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.illegal  = 1'b0;

    // Reset cycle keeps every enable low, even mid-instruction.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          bus.ALUSrcB  = SRCB_FOUR;
          if (bus.mem_ready) begin
            bus.IRWrite  = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
          end
        end

        S_DECODE: begin
          // Branch target computed speculatively into ALUOut.
          bus.ALUSrcB = SRCB_IMMSH;
          case (bus.opcode)
            OP_LW: begin
              state_d    = S_MEMADR;
              is_store_d = 1'b0;
            end
            OP_SW: begin
              state_d    = S_MEMADR;
              is_store_d = 1'b1;
            end
            OP_RTYPE:                  state_d = S_RTYPE_EX;
            OP_BEQ, OP_BNE:            state_d = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI: state_d = S_IMM_EX;
            OP_J:                      state_d = S_JUMP;
            default: begin
              bus.illegal = 1'b1;
              state_d     = S_FETCH;
            end
          endcase
        end

        S_MEMADR: begin
          bus.ALUSrcA = SRCA_REGA;
          bus.ALUSrcB = SRCB_IMM;
          state_d     = is_store_q ? S_MEMWR : S_MEMRD;
        end

        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.IorD     = 1'b1;
          if (bus.mem_ready) state_d = S_MEMWB;
        end

        S_MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
          state_d      = S_FETCH;
        end

        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.IorD      = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end

        S_RTYPE_EX: begin
          bus.ALUSrcA = SRCA_REGA;
          if (rt_valid) begin
            bus.ALU_opc = rt_opc;
            state_d     = S_RTYPE_WB;
          end else begin
            bus.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        end

        S_RTYPE_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
          state_d      = S_FETCH;
        end

        S_BRANCH: begin
          bus.ALUSrcA  = SRCA_REGA;
          bus.ALU_opc  = ALU_SUB;
          bus.PCSrc    = PCSRC_OUT;
          bus.pc_write = (bus.opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
          state_d      = S_FETCH;
        end

        S_IMM_EX: begin
          bus.ALUSrcA = SRCA_REGA;
          bus.ALUSrcB = SRCB_IMM;
          case (bus.opcode)
            OP_SLTI: bus.ALU_opc = ALU_SLT;
            OP_ANDI: bus.ALU_opc = ALU_AND;
            default: bus.ALU_opc = ALU_ADD;
          endcase
          state_d = S_IMM_WB;
        end

        S_IMM_WB: begin
          bus.RegWrite = 1'b1;
          state_d      = S_FETCH;
        end

        S_JUMP: begin
          bus.PCSrc    = PCSRC_JUMP;
          bus.pc_write = 1'b1;
          state_d      = S_FETCH;
        end

        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: per-cycle state and control
// vector checks against hand-computed values.
module tb_mc_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mc_controller_if bus ();

  mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALU_opc, SrcA, SrcB, PCSrc, pc_write, IorD, mem_read, mem_write,
  //  IRWrite, RegDst, MemtoReg, RegWrite, illegal}
  logic [16:0] ctl_vec;
  assign ctl_vec = {bus.ALU_opc, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc,
                    bus.pc_write, bus.IorD, bus.mem_read, bus.mem_write,
                    bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                    bus.illegal};

  function automatic logic [16:0] cv(input logic [2:0] alu, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] pcs,
                                     input logic pcw, input logic iord,
                                     input logic mr, input logic mw,
                                     input logic irw, input logic rd,
                                     input logic m2r, input logic rw,
                                     input logic ill);
    return {alu, sa, sb, pcs, pcw, iord, mr, mw, irw, rd, m2r, rw, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at negedge, then check state and control vector.
  task automatic cyc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic r,
                     input int st, input logic [16:0] v);
    @(negedge clk);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.Zero      = z;
    bus.mem_ready = rdy;
    rst           = r;
    #1;
    check({tag, "/state"}, 32'(dut.state_q), 32'(st));
    check({tag, "/ctl"}, 32'(ctl_vec), 32'(v));
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, JMP = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic [16:0] v_rst, v_fw, v_fr, v_dec, v_dec_ill, v_madr, v_mrd, v_mwb, v_mwr;
  logic [16:0] v_rslt, v_rsub, v_rill, v_rwb, v_br0, v_br1, v_iadd, v_islt, v_iand;
  logic [16:0] v_iwb, v_jmp;

  // Fetch (ready first try) then decode of opcode op.
  task automatic fd(input string tag, input logic [5:0] op, input logic [5:0] fn,
                    input logic [16:0] vdec);
    cyc({tag, "_fetch"}, op, fn, 1'b0, 1'b1, 1'b0, 0, v_fr);
    cyc({tag, "_dec"},   op, fn, 1'b0, 1'b1, 1'b0, 1, vdec);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    v_rst     = cv(3'b010,0,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
    v_fw      = cv(3'b010,0,2'b01,2'b00,0,0,1,0,0,0,0,0,0);
    v_fr      = cv(3'b010,0,2'b01,2'b00,1,0,1,0,1,0,0,0,0);
    v_dec     = cv(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0);
    v_dec_ill = cv(3'b010,0,2'b11,2'b00,0,0,0,0,0,0,0,0,1);
    v_madr    = cv(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
    v_mrd     = cv(3'b010,0,2'b00,2'b00,0,1,1,0,0,0,0,0,0);
    v_mwb     = cv(3'b010,0,2'b00,2'b00,0,0,0,0,0,0,1,1,0);
    v_mwr     = cv(3'b010,0,2'b00,2'b00,0,1,0,1,0,0,0,0,0);
    v_rslt    = cv(3'b100,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
    v_rsub    = cv(3'b011,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
    v_rill    = cv(3'b010,1,2'b00,2'b00,0,0,0,0,0,0,0,0,1);
    v_rwb     = cv(3'b010,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0);
    v_br0     = cv(3'b011,1,2'b00,2'b01,0,0,0,0,0,0,0,0,0);
    v_br1     = cv(3'b011,1,2'b00,2'b01,1,0,0,0,0,0,0,0,0);
    v_iadd    = cv(3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
    v_islt    = cv(3'b100,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
    v_iand    = cv(3'b000,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0);
    v_iwb     = cv(3'b010,0,2'b00,2'b00,0,0,0,0,0,0,0,1,0);
    v_jmp     = cv(3'b010,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0);

    // Reset held two cycles, then fetch stalls once before memory is ready.
    cyc("rst0", LW, 6'd0, 1'b0, 1'b1, 1'b1, 0, v_rst);
    cyc("rst1", LW, 6'd0, 1'b0, 1'b1, 1'b1, 0, v_rst);
    cyc("rel_fw", LW, 6'd0, 1'b0, 1'b0, 1'b0, 0, v_fw);

    // lw: 0,1,2,3,4; opcode changed in MEMADR/MEMRD must be ignored
    fd("lw", LW, 6'd0, v_dec);
    cyc("lw_madr", SW, 6'd0, 1'b0, 1'b1, 1'b0, 2, v_madr);
    cyc("lw_mrd",  BAD, 6'd0, 1'b0, 1'b1, 1'b0, 3, v_mrd);
    cyc("lw_mwb",  BAD, 6'd0, 1'b0, 1'b1, 1'b0, 4, v_mwb);

    // sw with three wait cycles in MEMWR: 7 cycles total
    fd("sw", SW, 6'd0, v_dec);
    cyc("sw_madr", SW, 6'd0, 1'b0, 1'b1, 1'b0, 2, v_madr);
    cyc("sw_mwr0", RT, 6'd0, 1'b0, 1'b0, 1'b0, 5, v_mwr);
    cyc("sw_mwr1", RT, 6'd0, 1'b0, 1'b0, 1'b0, 5, v_mwr);
    cyc("sw_mwr2", RT, 6'd0, 1'b0, 1'b0, 1'b0, 5, v_mwr);
    cyc("sw_mwr3", RT, 6'd0, 1'b0, 1'b1, 1'b0, 5, v_mwr);

    // R-type slt and sub
    fd("slt", RT, 6'b101010, v_dec);
    cyc("slt_ex", RT, 6'b101010, 1'b0, 1'b1, 1'b0, 6, v_rslt);
    cyc("slt_wb", RT, 6'b101010, 1'b0, 1'b1, 1'b0, 7, v_rwb);
    fd("sub", RT, 6'b100010, v_dec);
    cyc("sub_ex", RT, 6'b100010, 1'b0, 1'b1, 1'b0, 6, v_rsub);
    cyc("sub_wb", RT, 6'b100010, 1'b0, 1'b1, 1'b0, 7, v_rwb);

    // Unknown funct: illegal in EX, no write-back
    fd("badfn", RT, 6'b000111, v_dec);
    cyc("badfn_ex", RT, 6'b000111, 1'b0, 1'b1, 1'b0, 6, v_rill);

    // Branches, both Zero values
    fd("beq1", BEQ, 6'd0, v_dec);
    cyc("beq1_br", BEQ, 6'd0, 1'b1, 1'b1, 1'b0, 8, v_br1);
    fd("beq0", BEQ, 6'd0, v_dec);
    cyc("beq0_br", BEQ, 6'd0, 1'b0, 1'b1, 1'b0, 8, v_br0);
    fd("bne1", BNE, 6'd0, v_dec);
    cyc("bne1_br", BNE, 6'd0, 1'b1, 1'b1, 1'b0, 8, v_br0);
    fd("bne0", BNE, 6'd0, v_dec);
    cyc("bne0_br", BNE, 6'd0, 1'b0, 1'b1, 1'b0, 8, v_br1);

    // Immediates
    fd("addi", ADDI, 6'd0, v_dec);
    cyc("addi_ex", ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 9, v_iadd);
    cyc("addi_wb", ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 10, v_iwb);
    fd("slti", SLTI, 6'd0, v_dec);
    cyc("slti_ex", SLTI, 6'd0, 1'b0, 1'b1, 1'b0, 9, v_islt);
    cyc("slti_wb", SLTI, 6'd0, 1'b0, 1'b1, 1'b0, 10, v_iwb);
    fd("andi", ANDI, 6'd0, v_dec);
    cyc("andi_ex", ANDI, 6'd0, 1'b0, 1'b1, 1'b0, 9, v_iand);
    cyc("andi_wb", ANDI, 6'd0, 1'b0, 1'b1, 1'b0, 10, v_iwb);

    // Jump
    fd("j", JMP, 6'd0, v_dec);
    cyc("j_jmp", JMP, 6'd0, 1'b0, 1'b1, 1'b0, 11, v_jmp);

    // Illegal opcode: pulse in decode, straight back to fetch
    fd("bad", BAD, 6'd0, v_dec_ill);

    // Reset asserted while in MEMRD
    fd("lwr", LW, 6'd0, v_dec);
    cyc("lwr_madr", LW, 6'd0, 1'b0, 1'b1, 1'b0, 2, v_madr);
    cyc("lwr_rst",  LW, 6'd0, 1'b0, 1'b1, 1'b1, 3, v_rst);
    cyc("lwr_back", LW, 6'd0, 1'b0, 1'b0, 1'b0, 0, v_fw);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
